fetch_sequencer: RTL

//  Program-counter controller for the 4096 x 9-bit instruction ROM.
//  - Drives the ROM address, sequences program execution and applies branch/jump redirects.
//  - Provides a Start/Done handshake to the testbench or top level.
//  - The ROM is combinational, so the instruction at InstAddress is valid in the same cycle.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_sequencer_pc_next_calc.sv | 19 +
 rtl/fetch_sequencer.sv | 64 ++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset address, FSM state type and offset sign-extension
// for the instruction fetch sequencer.
package fetch_pkg;
    localparam int PC_W = 12;
    localparam int OFS_W = 9;
    typedef logic [PC_W-1:0] pc_t;
    localparam pc_t START_ADDR = '0;
    typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t;
    function automatic pc_t sext_ofs(input logic [OFS_W-1:0] ofs);
        return {{(PC_W-OFS_W){ofs[OFS_W-1]}}, ofs};
    endfunction
endpackage

// File: rtl/fetch_sequencer_pc_next_calc.sv
// pc_next_calc: combinational next-PC selection while running
// (stall/halt hold, then jump, then relative branch, then sequential increment).
module pc_next_calc
    import fetch_pkg::*;
(
    input  pc_t              pc_i,
    input  logic             stall_i,
    input  logic             halt_i,
    input  logic             jump_en_i,
    input  pc_t              jump_target_i,
    input  logic             branch_taken_i,
    input  logic [OFS_W-1:0] branch_ofs_i,
    output pc_t              pc_next_o
);
    assign pc_next_o = (stall_i || halt_i) ? pc_i :
                       jump_en_i           ? jump_target_i :
                       branch_taken_i      ? pc_i + sext_ofs(branch_ofs_i) :
                                             pc_i + pc_t'(1);
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter register and IDLE/RUN/HALTED control FSM
// driving the combinational instruction ROM address.
module fetch_sequencer
    import fetch_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stall,
    input  logic             HaltReq,
    input  logic             BranchTaken,
    input  logic [OFS_W-1:0] BranchOfs,
    input  logic             JumpEn,
    input  logic [PC_W-1:0]  JumpTarget,
    output logic [PC_W-1:0]  InstAddress,
    output logic             FetchValid,
    output logic             Busy,
    output logic             Done
);
    fetch_state_t state_q, state_d;
    pc_t          pc_q, pc_d, pc_run;

    pc_next_calc u_pc_next_calc (
        .pc_i           (pc_q),
        .stall_i        (Stall),
        .halt_i         (HaltReq),
        .jump_en_i      (JumpEn),
        .jump_target_i  (JumpTarget),
        .branch_taken_i (BranchTaken),
        .branch_ofs_i   (BranchOfs),
        .pc_next_o      (pc_run)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // IDLE and HALTED behave identically: wait for Start, PC frozen.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            RUN: begin
                pc_d    = pc_run;
                state_d = (!Stall && HaltReq) ? HALTED : RUN;
            end
            default: if (Start) begin
                state_d = RUN;
                pc_d    = START_ADDR;
            end
        endcase
    end

    assign InstAddress = pc_q;
    assign Busy        = (state_q == RUN);
    assign FetchValid  = (state_q == RUN);
    assign Done        = (state_q == HALTED);
endmodule
